out_frame_buf: RTL
==================

Name: out_frame_buf

Overview:
- Stereo output buffer that sits directly upstream of the two per-channel parallel-to-serial (P2S) serializers.
- Accepts 40-bit filter results from the compute datapath through a valid/ready handshake and queues them per channel.
- On each FRAME pulse, issues a simultaneous one-cycle LOAD and 40-bit parallel word to the left and right serializers.
- Guards against frame slips (FRAME while a transmission is still in progress) and underruns (FRAME with a channel queue empty).

Parameters:
- DEPTH, 4: entries per channel FIFO; power of two, at least 2.
- SAMPLE_W, 40: sample width; must equal the serializer parallel width.

Ports:
- SCLK  input  1  system clock; single clock domain.
- CLR  input  1  reset; asynchronous, active-high.
- WR_VALID  input  1  compute result valid.
- WR_CH  input  1  result channel; 0 = left, 1 = right.
- WR_DATA  input  SAMPLE_W  result word.
- WR_READY  output  1  high when the FIFO selected by WR_CH is not full.
- FRAME  input  1  one-cycle output frame strobe.
- OUTREADY_L  input  1  OutReady from the left serializer.
- OUTREADY_R  input  1  OutReady from the right serializer.
- LOAD_L  output  1  one-cycle load strobe to the left serializer.
- LOAD_R  output  1  one-cycle load strobe to the right serializer.
- PDATA_L  output  SAMPLE_W  parallel word to the left serializer.
- PDATA_R  output  SAMPLE_W  parallel word to the right serializer.
- UNDERRUN  output  1  sticky; set when a channel was empty at issue.
- FRAME_SLIP  output  1  sticky; set when a FRAME was dropped.
- LEVEL_L  output  clog2(DEPTH+1)  left FIFO occupancy.
- LEVEL_R  output  clog2(DEPTH+1)  right FIFO occupancy.

Behaviour:
- Reset (CLR high, asynchronous):
  - All FIFO pointers and levels go to 0; FSM goes to IDLE.
  - LOAD_L, LOAD_R, PDATA_L, PDATA_R, UNDERRUN and FRAME_SLIP all go to 0.
  - WR_READY reads 1 because both FIFOs are empty.
  - CLR mid-frame aborts the frame; any pending LOAD is not issued.
- Push:
  - A push occurs on an edge where WR_VALID and WR_READY are both high; WR_DATA goes into FIFO[WR_CH].
  - WR_READY is combinational: not full[WR_CH]. A pop in the same cycle does not free space, so there is no pass-through.
- FSM states: IDLE, ISSUE, WAIT_TX.
  - IDLE: on FRAME, go to ISSUE.
  - ISSUE: lasts one cycle. LOAD_L and LOAD_R are both high this cycle. PDATA_L and PDATA_R are registered and hold the FIFO head words. Each non-empty FIFO pops at the end of the cycle. Next state is WAIT_TX.
  - WAIT_TX: stay while OUTREADY_L or OUTREADY_R is high; go to IDLE when both are low.
  - PDATA_L and PDATA_R hold their values outside ISSUE.
- Latency: FRAME sampled at edge t makes LOAD high in cycle t+1. Serializer OutReady is high from t+2.
- Underrun: if a FIFO is empty in ISSUE, that channel's PDATA is all zeros (see Optional Feature). LOAD is still asserted for that channel and UNDERRUN is set.
- FRAME in ISSUE or WAIT_TX: the frame is ignored and FRAME_SLIP is set.
- Sticky flags clear only on CLR.
- Simultaneous push and pop on the same channel: both take effect and the level is unchanged.
- Pointers wrap modulo DEPTH.
- Data passes through unchanged; serial bit order is the serializer's responsibility.

Optional Feature:
- Macro: OUT_HOLD_LAST_EN.
- Defined: an underrun channel re-sends its last successfully issued word; after reset that word is 0. UNDERRUN is still set.
- Undefined: an underrun channel sends zeros.

Decomposition:
- Shared package msdap_pkg holds:
  - SAMPLE_W = 40.
  - Channel enum: CH_L = 0, CH_R = 1.
  - FSM state enum: IDLE, ISSUE, WAIT_TX.
- One natural sub-module, out_chan_fifo:
  - Single-clock, DEPTH-entry FIFO with push, pop, head data, full, empty and level outputs.
  - Instantiated twice, once per channel.

Test Plan:
- Basic frame: push L = 40'h12_3456_789A and R = 40'h80_0000_0001, then pulse FRAME. Expect LOAD_L = LOAD_R = 1 for exactly one cycle, one cycle after FRAME, with those PDATA values. Both levels return to 0 and no flags are set.
- Full and backpressure: push 4 left words with DEPTH = 4. Expect WR_READY = 0 for WR_CH = 0 and WR_READY = 1 for WR_CH = 1. A fifth left push is held off; LEVEL_L = 4.
- Underrun: push left only, then FRAME. Expect PDATA_R = 0, UNDERRUN = 1 and LOAD_R still pulsed. With OUT_HOLD_LAST_EN, expect PDATA_R equal to the previous right word.
- Frame slip: FRAME, then a second FRAME 10 cycles later while OUTREADY_L is high. Expect no second LOAD and FRAME_SLIP = 1. A FRAME after both OUTREADY inputs go low issues normally.
- Simultaneous push and pop: with LEVEL_L = 2, push left during the ISSUE cycle. Expect LEVEL_L stays 2 and FIFO order is preserved across a pointer wrap (8 frames).
- Reset mid-frame: assert CLR during WAIT_TX. Expect LOAD, PDATA, flags and levels go to 0 immediately, FSM returns to IDLE, and WR_READY = 1.

Source files
------------

// File: rtl/msdap_pkg.sv
// Shared definitions for the MSDAP output path: sample width, channel ids
// and the output-frame FSM state encoding.
package msdap_pkg;

  localparam int SAMPLE_W = 40;

  typedef enum logic {
    CH_L = 1'b0,
    CH_R = 1'b1
  } chan_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_TX = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/out_frame_buf_if.sv
// Signal bundle between the compute datapath / serializers (master side)
// and the output frame buffer (slave side).
//
// Handshake: a write is accepted on a rising SCLK edge where WR_VALID and
// WR_READY are both high. WR_READY depends combinationally on WR_CH only,
// never on WR_VALID, so the master may hold WR_VALID/WR_CH/WR_DATA stable
// until accepted without creating a loop.
interface out_frame_buf_if #(
  parameter int DEPTH    = 4,
  parameter int SAMPLE_W = msdap_pkg::SAMPLE_W
);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic                WR_VALID;
  logic                WR_CH;
  logic [SAMPLE_W-1:0] WR_DATA;
  logic                WR_READY;
  logic                FRAME;
  logic                OUTREADY_L;
  logic                OUTREADY_R;
  logic                LOAD_L;
  logic                LOAD_R;
  logic [SAMPLE_W-1:0] PDATA_L;
  logic [SAMPLE_W-1:0] PDATA_R;
  logic                UNDERRUN;
  logic                FRAME_SLIP;
  logic [LVL_W-1:0]    LEVEL_L;
  logic [LVL_W-1:0]    LEVEL_R;
  logic [1:0]          dbg_state;

  modport master (
    output WR_VALID, WR_CH, WR_DATA, FRAME, OUTREADY_L, OUTREADY_R,
    input  WR_READY, LOAD_L, LOAD_R, PDATA_L, PDATA_R, UNDERRUN,
           FRAME_SLIP, LEVEL_L, LEVEL_R, dbg_state
  );

  modport slave (
    input  WR_VALID, WR_CH, WR_DATA, FRAME, OUTREADY_L, OUTREADY_R,
    output WR_READY, LOAD_L, LOAD_R, PDATA_L, PDATA_R, UNDERRUN,
           FRAME_SLIP, LEVEL_L, LEVEL_R, dbg_state
  );

endinterface

// File: rtl/out_chan_fifo.sv
// Single-clock per-channel sample FIFO. Head word is visible on rdata
// whenever not empty. A pop never frees space for a push in the same cycle
// because full is taken from the registered level.
module out_chan_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 40,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     wdata,
  input  logic             pop,
  output logic [W-1:0]     rdata,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop) level_d = level_q + LVL_W'(1);
    if (!do_push && do_pop) level_d = level_q - LVL_W'(1);
  end

  // Pointer and level registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/out_frame_buf.sv
// Stereo output frame buffer feeding the left/right P2S serializers.
// Per-channel FIFOs are filled from the compute datapath; each accepted
// FRAME produces one ISSUE cycle with LOAD_L/LOAD_R high and registered
// PDATA words, then waits until both serializers drop OutReady.
// Optional build macro: OUT_HOLD_LAST_EN (underrun channel repeats its
// last issued word instead of sending zeros).
module out_frame_buf #(
  parameter int DEPTH    = 4,
  parameter int SAMPLE_W = msdap_pkg::SAMPLE_W
) (
  input logic            SCLK,
  input logic            CLR,
  out_frame_buf_if.slave bus
);
  import msdap_pkg::*;

  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_ISSUE   = ISSUE;
  localparam logic [1:0] ST_WAIT_TX = WAIT_TX;

  logic [1:0]          state_q, state_d;
  logic                avail_l_q, avail_l_d, avail_r_q, avail_r_d;
  logic [SAMPLE_W-1:0] pdata_l_q, pdata_l_d, pdata_r_q, pdata_r_d;
  logic                underrun_q, underrun_d, slip_q, slip_d;
  logic [SAMPLE_W-1:0] head_l, head_r, fill_l, fill_r;
  logic                full_l, full_r, empty_l, empty_r;
  logic [LVL_W-1:0]    level_l, level_r;
  logic                wr_ready, push_l, push_r, pop_l, pop_r;

  assign wr_ready = (bus.WR_CH == CH_R) ? !full_r : !full_l;
  assign push_l   = bus.WR_VALID && wr_ready && (bus.WR_CH == CH_L);
  assign push_r   = bus.WR_VALID && wr_ready && (bus.WR_CH == CH_R);
  // Only words actually captured into PDATA are popped; a word pushed on
  // the FRAME edge into an empty FIFO waits for the next frame.
  assign pop_l    = (state_q == ST_ISSUE) && avail_l_q;
  assign pop_r    = (state_q == ST_ISSUE) && avail_r_q;

  out_chan_fifo #(.DEPTH(DEPTH), .W(SAMPLE_W)) u_fifo_l (
    .clk(SCLK), .rst(CLR), .push(push_l), .wdata(bus.WR_DATA), .pop(pop_l),
    .rdata(head_l), .full(full_l), .empty(empty_l), .level(level_l)
  );

  out_chan_fifo #(.DEPTH(DEPTH), .W(SAMPLE_W)) u_fifo_r (
    .clk(SCLK), .rst(CLR), .push(push_r), .wdata(bus.WR_DATA), .pop(pop_r),
    .rdata(head_r), .full(full_r), .empty(empty_r), .level(level_r)
  );

  // Word sent on an empty channel. PDATA only changes on issue, so it
  // already holds the last successfully issued word (0 after reset).
  always_comb begin
`ifdef OUT_HOLD_LAST_EN
    fill_l = pdata_l_q;
    fill_r = pdata_r_q;
`else
    fill_l = '0;
    fill_r = '0;
`endif
  end

  // Frame FSM: capture heads on FRAME, issue for one cycle, wait for TX.
  always_comb begin
    state_d    = state_q;
    avail_l_d  = avail_l_q;
    avail_r_d  = avail_r_q;
    pdata_l_d  = pdata_l_q;
    pdata_r_d  = pdata_r_q;
    underrun_d = underrun_q;
    slip_d     = slip_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.FRAME) begin
          state_d   = ST_ISSUE;
          avail_l_d = !empty_l;
          avail_r_d = !empty_r;
          pdata_l_d = empty_l ? fill_l : head_l;
          pdata_r_d = empty_r ? fill_r : head_r;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_TX;
        if (bus.FRAME) slip_d = 1'b1;
        if (!avail_l_q || !avail_r_q) underrun_d = 1'b1;
      end
      ST_WAIT_TX: begin
        if (bus.FRAME) slip_d = 1'b1;
        if (!bus.OUTREADY_L && !bus.OUTREADY_R) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and output registers.
  always_ff @(posedge SCLK or posedge CLR) begin
    if (CLR) begin
      state_q    <= ST_IDLE;
      avail_l_q  <= 1'b0;
      avail_r_q  <= 1'b0;
      pdata_l_q  <= '0;
      pdata_r_q  <= '0;
      underrun_q <= 1'b0;
      slip_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      avail_l_q  <= avail_l_d;
      avail_r_q  <= avail_r_d;
      pdata_l_q  <= pdata_l_d;
      pdata_r_q  <= pdata_r_d;
      underrun_q <= underrun_d;
      slip_q     <= slip_d;
    end
  end

  assign bus.WR_READY   = wr_ready;
  assign bus.LOAD_L     = (state_q == ST_ISSUE);
  assign bus.LOAD_R     = (state_q == ST_ISSUE);
  assign bus.PDATA_L    = pdata_l_q;
  assign bus.PDATA_R    = pdata_r_q;
  assign bus.UNDERRUN   = underrun_q;
  assign bus.FRAME_SLIP = slip_q;
  assign bus.LEVEL_L    = level_l;
  assign bus.LEVEL_R    = level_r;
  assign bus.dbg_state  = state_q;

endmodule
